// File: rtl/pattern_match_pkg.sv
// pattern_match_pkg: scheduler FSM encoding, default sizing and the ID-width helper.
package pattern_match_pkg;
   typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;
   localparam int DEF_N = 4;
   localparam int DEF_W = 48;
   localparam int DEF_LAT = 2;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/pm_compare_pipe.sv
// pm_compare_pipe: masked pattern compare with a LAT-deep valid/ID/result shift register.
module pm_compare_pipe
   import pattern_match_pkg::*;
#(
   parameter int W = DEF_W,
   parameter int LAT = DEF_LAT,
   parameter int IW = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   input  logic [IW-1:0] in_id,
   input  logic [W-1:0] ain,
   input  logic [W-1:0] cin,
   input  logic [W-1:0] mask,
   output logic res_valid,
   output logic [IW-1:0] res_id,
   output logic res_match,
   output logic empty
);
   localparam int D = (LAT > 1) ? LAT - 1 : 1;
   logic h_v, h_m, h_busy;
   logic [IW-1:0] h_id;
   logic [D-1:0] v_c, m_c, v_sh, m_sh;
   logic [IW-1:0] id_c [D];
   logic [IW-1:0] id_sh [D];
   if (LAT > 1) begin : g_s1
      logic [W-1:0] a_q, c_q, k_q;
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            h_v <= 1'b0;
            h_id <= '0;
            a_q <= '0;
            c_q <= '0;
            k_q <= '0;
         end else begin
            h_v <= in_valid;
            if (in_valid) begin
               h_id <= in_id;
               a_q <= ain;
               c_q <= cin;
               k_q <= mask;
            end
         end
      assign h_m = ~|((a_q ^ c_q) & ~k_q);
      assign h_busy = h_v;
   end else begin : g_s0
      assign h_v = in_valid;
      assign h_id = in_id;
      assign h_m = ~|((ain ^ cin) & ~mask);
      assign h_busy = 1'b0;
   end
   always_comb begin
      v_c = D'({v_sh, h_v});
      m_c = D'({m_sh, h_m});
      id_c[0] = h_id;
      for (int i = 1; i < D; i++) id_c[i] = id_sh[i-1];
   end
   // ID/result only advance with a valid bit, so the final stage holds between results
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         v_sh <= '0;
         m_sh <= '0;
         for (int i = 0; i < D; i++) id_sh[i] <= '0;
      end else begin
         v_sh <= v_c;
         for (int i = 0; i < D; i++)
            if (v_c[i]) begin
               m_sh[i] <= m_c[i];
               id_sh[i] <= id_c[i];
            end
      end
   assign res_valid = v_sh[D-1];
   assign res_id = id_sh[D-1];
   assign res_match = m_sh[D-1];
   assign empty = ~|v_sh & ~h_busy;
endmodule

// File: rtl/pattern_match_sched.sv
// pattern_match_sched: round-robin scheduler sharing one pipelined masked pattern-match datapath.
// Optional per-requester match counters: PATTERN_MATCH_SCHED_MATCH_COUNT_EN.
module pattern_match_sched
   import pattern_match_pkg::*;
#(
   parameter int N = DEF_N,
   parameter int W = DEF_W,
   parameter int LAT = DEF_LAT,
   parameter int CW = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic [N-1:0] req_valid,
   output logic [N-1:0] req_ready,
   input  logic [N*W-1:0] req_ain,
   input  logic [N*W-1:0] req_cin,
   input  logic cfg_we,
   input  logic [W-1:0] cfg_mask,
   output logic cfg_busy,
   output logic res_valid,
   output logic [clog2(N)-1:0] res_id,
   output logic pattern_match_out
`ifdef PATTERN_MATCH_SCHED_MATCH_COUNT_EN
   ,
   output logic [N*CW-1:0] match_cnt
`endif
);
   localparam int IW = clog2(N);
   state_t st, nxt;
   logic [W-1:0] mask, pend;
   logic [IW-1:0] ptr, gid, idx;
   logic found, xfer, empty;
   always_comb begin
      found = 1'b0;
      gid = '0;
      idx = '0;
      for (int k = 0; k < N; k++) begin
         idx = IW'((int'(ptr) + k) % N);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            gid = idx;
         end
      end
   end
   // a mask write takes priority over grants in the same cycle
   assign xfer = found & (st == RUN) & ~cfg_we & rst_n;
   assign req_ready = xfer ? N'(1) << gid : '0;
   assign cfg_busy = st != RUN;
   always_comb nxt = (st == RUN) ? (cfg_we ? DRAIN : RUN) : (st == DRAIN) ? (empty ? LOAD : DRAIN) : RUN;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st <= RUN;
         mask <= '0;
         pend <= '0;
         ptr <= '0;
      end else begin
         st <= nxt;
         if (st == RUN && cfg_we) pend <= cfg_mask;
         if (st == LOAD) mask <= pend;
         if (xfer) ptr <= (int'(gid) == N - 1) ? '0 : gid + 1'b1;
      end
   pm_compare_pipe #(.W(W), .LAT(LAT), .IW(IW)) u_pipe (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(xfer),
      .in_id(gid),
      .ain(req_ain[int'(gid)*W +: W]),
      .cin(req_cin[int'(gid)*W +: W]),
      .mask(mask),
      .res_valid(res_valid),
      .res_id(res_id),
      .res_match(pattern_match_out),
      .empty(empty)
   );
`ifdef PATTERN_MATCH_SCHED_MATCH_COUNT_EN
   logic [CW-1:0] cnt [N];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) for (int i = 0; i < N; i++) cnt[i] <= '0;
      else if (st == LOAD) for (int i = 0; i < N; i++) cnt[i] <= '0;
      else if (res_valid && pattern_match_out && !(&cnt[res_id])) cnt[res_id] <= cnt[res_id] + 1'b1;
   for (genvar i = 0; i < N; i++) begin : g_cnt
      assign match_cnt[i*CW +: CW] = cnt[i];
   end
`endif
endmodule

// File: tb/tb_pattern_match_sched.sv
// tb_pattern_match_sched: scoreboard bench for the round-robin pattern-match scheduler.
`timescale 1ns/1ps
module tb_pattern_match_sched;
   localparam int N = 4;
   localparam int W = 48;
   localparam int LAT = 2;
   localparam int IW = 2;
`ifdef PATTERN_MATCH_SCHED_MATCH_COUNT_EN
   localparam int CW = 2;
`else
   localparam int CW = 16;
`endif
   localparam int M_RUN = 0;
   localparam int M_DRAIN = 1;
   localparam int M_LOAD = 2;
   typedef struct {int due; int id; logic m;} exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [N-1:0] req_valid, req_ready;
   logic [N*W-1:0] req_ain, req_cin;
   logic cfg_we, cfg_busy, res_valid, pattern_match_out;
   logic [W-1:0] cfg_mask;
   logic [IW-1:0] res_id;
`ifdef PATTERN_MATCH_SCHED_MATCH_COUNT_EN
   logic [N*CW-1:0] match_cnt;
`endif
   exp_t q[$];
   int seen[$];
   int n_cmp = 0, n_bad = 0, cyc = 0, m_st = 0, m_ptr = 0;
   int m_cnt [N];
   logic [W-1:0] m_mask, m_pend;
   always #5 clk = ~clk;
   pattern_match_sched #(.N(N), .W(W), .LAT(LAT), .CW(CW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_ain(req_ain),
      .req_cin(req_cin),
      .cfg_we(cfg_we),
      .cfg_mask(cfg_mask),
      .cfg_busy(cfg_busy),
      .res_valid(res_valid),
      .res_id(res_id),
      .pattern_match_out(pattern_match_out)
`ifdef PATTERN_MATCH_SCHED_MATCH_COUNT_EN
      ,
      .match_cnt(match_cnt)
`endif
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic put(input int i, input logic [W-1:0] a, input logic [W-1:0] c);
      req_valid[i] = 1'b1;
      req_ain[i*W +: W] = a;
      req_cin[i*W +: W] = c;
   endtask
   task automatic idle();
      req_valid = '0;
      cfg_we = 1'b0;
   endtask
   task automatic mreset();
      q.delete();
      m_st = M_RUN;
      m_ptr = 0;
      m_mask = '0;
      m_pend = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
   endtask
   // one clock: inputs already driven; check at negedge, advance the model, return at posedge+1
   task automatic tick();
      logic [N-1:0] er;
      logic emp, m;
      int gid;
      exp_t e;
      @(negedge clk);
      cyc++;
      emp = (q.size() == 0);
      chk("busy", cfg_busy, m_st != M_RUN);
`ifdef PATTERN_MATCH_SCHED_MATCH_COUNT_EN
      for (int i = 0; i < N; i++) chk("cnt", match_cnt[i*CW +: CW], m_cnt[i]);
`endif
      er = '0;
      gid = 0;
      if (m_st == M_RUN && !cfg_we)
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (er == '0 && req_valid[j]) begin
               er[j] = 1'b1;
               gid = j;
            end
         end
      chk("ready", req_ready, er);
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         chk("res_valid", res_valid, 1);
         chk("res_id", res_id, e.id);
         chk("match", pattern_match_out, e.m);
         seen.push_back(int'(res_id));
         if (e.m && m_cnt[e.id] < (1 << CW) - 1) m_cnt[e.id]++;
      end else chk("res_idle", res_valid, 0);
      if (er != '0) begin
         m = ((req_ain[gid*W +: W] ^ req_cin[gid*W +: W]) & ~m_mask) == '0;
         q.push_back('{cyc + LAT, gid, m});
         m_ptr = (gid + 1) % N;
      end
      case (m_st)
         M_RUN: if (cfg_we) begin
            m_pend = cfg_mask;
            m_st = M_DRAIN;
         end
         M_DRAIN: if (emp) m_st = M_LOAD;
         default: begin
            m_mask = m_pend;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_st = M_RUN;
         end
      endcase
      @(posedge clk);
      #1;
   endtask
   task automatic chk_reset();
      chk("rst_ready", req_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_id", res_id, 0);
      chk("rst_match", pattern_match_out, 0);
      chk("rst_busy", cfg_busy, 0);
   endtask
   initial begin
      idle();
      req_ain = '0;
      req_cin = '0;
      cfg_mask = '0;
      mreset();
      req_valid = '1;
      #2;
      chk_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle();
      tick();
      tick();
      // all requesters held valid: expect 0,1,2,3,0,1,2,3
      seen.delete();
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < N; i++) put(i, 48'(i * 100 + k), 48'(i * 100 + k + (i % 2)));
         tick();
      end
      idle();
      repeat (3) tick();
      chk("rr_count", seen.size(), 8);
      for (int k = 0; k < 8 && k < seen.size(); k++) chk("rr_order", seen[k], k % 4);
      put(0, 48'd510, 48'd512);
      tick();
      idle();
      repeat (3) tick();
      chk("m510_hold", pattern_match_out, 0);
      chk("m510_id_hold", res_id, 0);
      put(0, 48'd2025, 48'd2025);
      tick();
      idle();
      repeat (3) tick();
      chk("m2025_hold", pattern_match_out, 1);
      // mask update with two transfers in flight, second write during drain ignored
      put(2, 48'd510, 48'd512);
      tick();
      idle();
      put(3, 48'd7, 48'd7);
      tick();
      idle();
      cfg_we = 1'b1;
      cfg_mask = 48'h3FF;
      tick();
      chk("cfg_busy_drain", cfg_busy, 1);
      cfg_we = 1'b1;
      cfg_mask = '0;
      put(0, 48'd510, 48'd512);
      tick();
      cfg_we = 1'b0;
      repeat (3) tick();
      idle();
      repeat (3) tick();
      chk("masked_match", pattern_match_out, 1);
      chk("masked_id", res_id, 0);
      chk("busy_done", cfg_busy, 0);
      // reset with two transfers in flight
      put(1, 48'd1, 48'd1);
      tick();
      idle();
      put(2, 48'd5, 48'd6);
      tick();
      req_valid = '1;
      rst_n = 1'b0;
      mreset();
      #1;
      chk_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle();
      repeat (3) tick();
      req_valid = '1;
      tick();
      idle();
      repeat (3) tick();
`ifdef PATTERN_MATCH_SCHED_MATCH_COUNT_EN
      for (int k = 0; k < 3; k++) begin
         put(1, 48'd1115, 48'd1115);
         tick();
         idle();
      end
      put(2, 48'd10, 48'd110);
      tick();
      idle();
      repeat (3) tick();
      chk("cnt1", match_cnt[1*CW +: CW], 3);
      chk("cnt2", match_cnt[2*CW +: CW], 0);
      for (int k = 0; k < 2; k++) begin
         put(1, 48'd1115, 48'd1115);
         tick();
         idle();
      end
      repeat (3) tick();
      chk("cnt1_sat", match_cnt[1*CW +: CW], 3);
`endif
      chk("sb_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
